// File: rtl/i2c_master_arbiter_if.sv
// Command/response bundle between the requester arbiter and the shared I2C master core.
// The "master" modport is the arbiter side; the "slave" modport is the I2C master core side.
interface i2c_master_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();

  logic              m_enable;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_nack;

  modport master (
    output m_enable,
    output m_addr,
    output m_rw,
    output m_wdata,
    input  m_ready,
    input  m_rdata,
    input  m_nack
  );

  modport slave (
    input  m_enable,
    input  m_addr,
    input  m_rw,
    input  m_wdata,
    output m_ready,
    output m_rdata,
    output m_nack
  );

endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer that shares one I2C master between N_REQ requesters.
// Each granted request is launched through the master's enable/ready handshake; the
// completion status (read byte, NACK, timeout) is returned to the winner with a done pulse.
module i2c_master_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_rw,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_nack,
  output logic                      rsp_timeout,
  output logic                      busy,
  i2c_master_arbiter_if.master      mif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  // Index that follows idx in the circular requester order.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_LAST) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  // First asserted request bit at or after ptr, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_nack_q, rsp_nack_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy_q, busy_d;
  logic               m_enable_q, m_enable_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic               m_rw_q, m_rw_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic [IDX_W-1:0]   pick_s;

  // Next-state and next-output computation for the arbiter/sequencer FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    winner_d      = winner_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    done_d        = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_nack_d    = rsp_nack_q;
    rsp_timeout_d = rsp_timeout_q;
    m_enable_d    = m_enable_q;
    m_addr_d      = m_addr_q;
    m_rw_d        = m_rw_q;
    m_wdata_d     = m_wdata_q;
    pick_s        = rr_pick(req, rr_ptr_q);

    case (state_q)
      ST_IDLE: begin
        if (mif.m_ready && (|req)) begin
          winner_d        = pick_s;
          m_rw_d          = req_rw[pick_s];
          m_addr_d        = req_addr[pick_s*ADDR_W +: ADDR_W];
          m_wdata_d       = req_wdata[pick_s*DATA_W +: DATA_W];
          gnt_d[pick_s]   = 1'b1;
          m_enable_d      = 1'b1;
          cnt_d           = '0;
          state_d         = ST_LAUNCH;
        end else begin
          m_enable_d = 1'b0;
        end
      end

      ST_LAUNCH: begin
        if (!mif.m_ready) begin
          // Master has accepted the start strobe.
          m_enable_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          m_enable_d         = 1'b0;
          rsp_timeout_d      = 1'b1;
          rsp_nack_d         = 1'b0;
          rsp_rdata_d        = '0;
          done_d[winner_q]   = 1'b1;
          state_d            = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        m_enable_d = 1'b0;
        if (mif.m_ready) begin
          rsp_rdata_d      = mif.m_rdata;
          rsp_nack_d       = mif.m_nack;
          done_d[winner_q] = 1'b1;
          state_d          = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d    = 1'b1;
          rsp_nack_d       = 1'b0;
          rsp_rdata_d      = '0;
          done_d[winner_q] = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        m_enable_d    = 1'b0;
        rr_ptr_d      = next_idx(winner_q);
        rsp_timeout_d = 1'b0;
        state_d       = ST_IDLE;
      end

      default: begin
        m_enable_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops; reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      rsp_rdata_q   <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      m_enable_q    <= 1'b0;
      m_addr_q      <= '0;
      m_rw_q        <= 1'b0;
      m_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_nack_q    <= rsp_nack_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      m_enable_q    <= m_enable_d;
      m_addr_q      <= m_addr_d;
      m_rw_q        <= m_rw_d;
      m_wdata_q     <= m_wdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_nack     = rsp_nack_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = busy_q;
  assign mif.m_enable = m_enable_q;
  assign mif.m_addr   = m_addr_q;
  assign mif.m_rw     = m_rw_q;
  assign mif.m_wdata  = m_wdata_q;

endmodule
